// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared widths, fetch timeout and fetch FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W     = 12;
  localparam int ADDR_W      = 8;
  localparam int OPCODE_W    = 4;
  localparam int ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module : program_counter
// Brief  : Program counter with jump load, wrapping increment, async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_pc
);

  logic [WIDTH-1:0] r_pc;

  // Load wins over increment; increment wraps naturally at the top address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + WIDTH'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module : instruction_fetch
// Brief  : Single-word instruction fetch FSM with ack timeout and IR strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int INSTR_W     = cpu_pkg::INSTR_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int ACK_TIMEOUT = cpu_pkg::ACK_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset_fetch,
  input  logic               fetch_go,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rd_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               REIR,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_busy,
  output logic               fetch_err
);

  localparam int              c_to_w    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(ACK_TIMEOUT - 1);

  cpu_pkg::fetch_state_t r_state;
  cpu_pkg::fetch_state_t w_next_state;

  logic [c_to_w-1:0]  r_to_cnt;
  logic [c_to_w-1:0]  w_to_cnt_next;
  logic               w_timeout;
  logic               r_err;
  logic [INSTR_W-1:0] r_instr;
  logic               w_pc_load;
  logic               w_pc_inc;
  logic               w_capture;

  always_comb begin
    w_next_state  = r_state;
    w_to_cnt_next = r_to_cnt;
    w_timeout     = 1'b0;
    case (r_state)
      cpu_pkg::IDLE: begin
        w_to_cnt_next = '0;
        if (fetch_go && !halt && !jump_en) begin
          w_next_state = cpu_pkg::REQ;
        end
      end
      cpu_pkg::REQ: begin
        // An ack arriving on the last allowed cycle still completes the fetch.
        if (mem_rd_ack) begin
          w_next_state  = cpu_pkg::LOAD;
          w_to_cnt_next = '0;
        end else if (r_to_cnt == c_to_last) begin
          w_next_state  = cpu_pkg::IDLE;
          w_to_cnt_next = '0;
          w_timeout     = 1'b1;
        end else begin
          w_to_cnt_next = r_to_cnt + c_to_w'(1);
        end
      end
      cpu_pkg::LOAD: begin
        w_next_state = cpu_pkg::IDLE;
      end
      default: begin
        w_next_state  = cpu_pkg::IDLE;
        w_to_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_fetch) begin
    if (reset_fetch) begin
      r_state  <= cpu_pkg::IDLE;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_to_cnt <= w_to_cnt_next;
      r_err    <= w_timeout;
    end
  end

  assign w_capture = (r_state == cpu_pkg::REQ) && mem_rd_ack;

  always_ff @(posedge clk or posedge reset_fetch) begin
    if (reset_fetch) begin
      r_instr <= '0;
    end else if (w_capture) begin
      r_instr <= mem_rdata;
    end
  end

  assign w_pc_load = (r_state == cpu_pkg::IDLE) && jump_en;
  assign w_pc_inc  = (r_state == cpu_pkg::LOAD);

  program_counter #(
    .WIDTH (ADDR_W)
  ) u_pc (
    .clk        (clk),
    .rst        (reset_fetch),
    .i_load     (w_pc_load),
    .i_load_val (jump_addr),
    .i_inc      (w_pc_inc),
    .o_pc       (pc)
  );

  assign mem_rd_req  = (r_state == cpu_pkg::REQ);
  assign mem_addr    = pc;
  assign REIR        = (r_state == cpu_pkg::LOAD);
  assign fetch_busy  = (r_state != cpu_pkg::IDLE);
  assign fetch_err   = r_err;
  assign instruction = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module : tb_instruction_fetch
// Brief  : Scoreboard bench for instruction_fetch using directed fetch vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam int ACK_TO = 16;

  logic        clk;
  logic        reset_fetch;
  logic        fetch_go;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halt;
  logic        mem_rd_req;
  logic [7:0]  mem_addr;
  logic        mem_rd_ack;
  logic [11:0] mem_rdata;
  logic [11:0] instruction;
  logic        REIR;
  logic [7:0]  pc;
  logic        fetch_busy;
  logic        fetch_err;

  instruction_fetch dut (
    .clk         (clk),
    .reset_fetch (reset_fetch),
    .fetch_go    (fetch_go),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .REIR        (REIR),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [11:0] instr;
    logic [7:0]  addr;
    logic [7:0]  pc_after;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input bit is_err, input logic [11:0] instr,
                      input logic [7:0] addr, input logic [7:0] pc_after);
    exp_t e;
    e.is_err   = is_err;
    e.instr    = instr;
    e.addr     = addr;
    e.pc_after = pc_after;
    sb_q.push_back(e);
  endtask

  task automatic do_fetch(input int delay, input logic [11:0] data,
                          input bit halt_mid, input bit jump_mid);
    step(); fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    halt    = halt_mid;
    jump_en = jump_mid;
    if (jump_mid) jump_addr = 8'h77;
    for (int i = 0; i < delay; i++) begin
      step();
      jump_en = 1'b0;
    end
    mem_rd_ack = 1'b1;
    mem_rdata  = data;
    step();
    mem_rd_ack = 1'b0;
    mem_rdata  = 12'hBAD;
    jump_en    = 1'b0;
    halt       = 1'b0;
    step();
    step();
  endtask

  // Monitor: pops the scoreboard on every IR strobe or timeout pulse.
  exp_t       cur;
  bit         pend = 1'b0;
  int         req_run = 0;
  logic [7:0] ack_addr = 8'h00;

  always @(negedge clk) begin
    if (reset_fetch) begin
      pend    = 1'b0;
      req_run = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        chk("pc_after", pc, cur.pc_after);
        chk("strobe_width", {REIR, fetch_err}, 2'b00);
      end
      if (mem_rd_req) begin
        req_run++;
        if (mem_rd_ack) ack_addr = mem_addr;
      end
      if (REIR || fetch_err) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_strobe: REIR=%0b fetch_err=%0b with empty scoreboard at %0t",
                   REIR, fetch_err, $time);
        end else begin
          cur  = sb_q.pop_front();
          pend = 1'b1;
          chk("strobe_kind", {REIR, fetch_err}, cur.is_err ? 2'b01 : 2'b10);
          chk("instruction", instruction, cur.instr);
          if (cur.is_err) begin
            chk("req_cycles_before_err", req_run, ACK_TO);
            chk("busy_at_err", fetch_busy, 1'b0);
            chk("pc_hold_on_err", pc, cur.pc_after);
          end else begin
            chk("fetch_addr", ack_addr, cur.addr);
            chk("pc_during_load", pc, cur.addr);
            chk("req_low_in_load", mem_rd_req, 1'b0);
          end
        end
      end
      if (!mem_rd_req) req_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_fetch = 1'b1;
    fetch_go    = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    halt        = 1'b0;
    mem_rd_ack  = 1'b0;
    mem_rdata   = 12'h000;
    #12;
    chk("rst_pc", pc, 8'h00);
    chk("rst_instr", instruction, 12'h000);
    chk("rst_flags", {REIR, mem_rd_req, fetch_busy, fetch_err}, 4'b0000);
    step(); reset_fetch = 1'b0;

    // First fetch after reset, immediate ack.
    push(1'b0, 12'h4FF, 8'h00, 8'h01);
    do_fetch(0, 12'h4FF, 1'b0, 1'b0);

    // halt blocks the start of a fetch.
    step(); halt = 1'b1; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    @(negedge clk);
    chk("halt_blocks_busy", {fetch_busy, mem_rd_req}, 2'b00);
    step(); halt = 1'b0;

    // Jump in IDLE wins over a same-cycle fetch_go.
    step(); jump_en = 1'b1; jump_addr = 8'h3C; fetch_go = 1'b1;
    step(); jump_en = 1'b0; fetch_go = 1'b0;
    @(negedge clk);
    chk("jump_pc", pc, 8'h3C);
    chk("jump_no_fetch", fetch_busy, 1'b0);
    push(1'b0, 12'h123, 8'h3C, 8'h3D);
    do_fetch(2, 12'h123, 1'b0, 1'b0);

    // Jump during REQ is ignored.
    push(1'b0, 12'h7E1, 8'h3D, 8'h3E);
    do_fetch(3, 12'h7E1, 1'b0, 1'b1);

    // halt raised mid-fetch does not abort.
    push(1'b0, 12'h5C3, 8'h3E, 8'h3F);
    do_fetch(3, 12'h5C3, 1'b1, 1'b0);

    // Ack withheld: timeout pulse, pc and instruction held.
    push(1'b1, 12'h5C3, 8'h3F, 8'h3F);
    step(); fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    repeat (ACK_TO + 4) step();
    @(negedge clk);
    chk("busy_after_timeout", fetch_busy, 1'b0);

    // Ack on the last allowed cycle still completes.
    push(1'b0, 12'h2B8, 8'h3F, 8'h40);
    do_fetch(ACK_TO - 1, 12'h2B8, 1'b0, 1'b0);

    // pc wrap from 8'hFF.
    step(); jump_en = 1'b1; jump_addr = 8'hFF;
    step(); jump_en = 1'b0;
    push(1'b0, 12'h0A5, 8'hFF, 8'h00);
    do_fetch(0, 12'h0A5, 1'b0, 1'b0);

    // Reset asserted during REQ aborts immediately.
    step(); jump_en = 1'b1; jump_addr = 8'h55;
    step(); jump_en = 1'b0; fetch_go = 1'b1;
    step(); fetch_go = 1'b0;
    step(); reset_fetch = 1'b1;
    #1;
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_instr", instruction, 12'h000);
    chk("midrst_flags", {REIR, mem_rd_req, fetch_busy, fetch_err}, 4'b0000);
    step(); step(); reset_fetch = 1'b0;

    push(1'b0, 12'h9E7, 8'h00, 8'h01);
    do_fetch(1, 12'h9E7, 1'b0, 1'b0);

    repeat (3) step();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: INSTR_W, 12, instruction word width (4-bit opcode + 8-bit operand/address).
REQ-002 Parameter: ADDR_W, 8, program address width.
REQ-003 Parameter: ACK_TIMEOUT, 16, cycles waited for mem_rd_ack before abort.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset_fetch  in  1  asynchronous, active-high reset.
REQ-006 Port: fetch_go  in  1  start one fetch at current pc.
REQ-007 Port: jump_en  in  1  load pc from jump_addr.
REQ-008 Port: jump_addr  in  ADDR_W  branch target.
REQ-009 Port: halt  in  1  level; blocks new fetches.
REQ-010 Port: mem_rd_req  out  1  program-memory read request.
REQ-011 Port: mem_addr  out  ADDR_W  read address, equals pc.
REQ-012 Port: mem_rd_ack  in  1  memory read acknowledge; mem_rdata valid in the same cycle.
REQ-013 Port: mem_rdata  in  INSTR_W  memory read data.
REQ-014 Port: instruction  out  INSTR_W  fetched word for the instruction register.
REQ-015 Port: REIR  out  1  one-cycle load strobe for the instruction register.
REQ-016 Port: pc  out  ADDR_W  program counter.
REQ-017 Port: fetch_busy  out  1  high in every state except IDLE.
REQ-018 Port: fetch_err  out  1  one-cycle pulse on ack timeout.

Function
REQ-019 FSM states SHALL be IDLE, REQ, LOAD.
REQ-020 IDLE: fetch_go=1, halt=0, jump_en=0 -> REQ; else stay.
REQ-021 IDLE, jump_en=1: pc <= jump_addr next edge; a same-cycle fetch_go SHALL be ignored.
REQ-022 jump_en outside IDLE SHALL be ignored; pc unchanged.
REQ-023 REQ: mem_rd_req=1, mem_addr=pc; on mem_rd_ack=1, capture mem_rdata into instruction and go to LOAD.
REQ-024 REQ: timeout counter increments each cycle without ack; after ACK_TIMEOUT ack-less cycles -> IDLE, fetch_err=1 for 1 cycle, pc and instruction unchanged.
REQ-025 LOAD: REIR=1 for exactly one cycle with instruction stable; pc <= pc+1 at the end of the cycle; then IDLE.
REQ-026 pc increment SHALL wrap 8'hFF -> 8'h00 without error.
REQ-027 Minimum latency: fetch_go sampled at edge k; REQ during cycle k..k+1; ack in that cycle -> REIR high during cycle k+1..k+2.
REQ-028 halt rising mid-fetch SHALL NOT abort the fetch; halt only gates IDLE -> REQ.
REQ-029 fetch_go outside IDLE SHALL be ignored (no queueing).
REQ-030 mem_rd_req SHALL be low in IDLE and LOAD; REIR SHALL be low outside LOAD.
REQ-031 instruction SHALL hold its last fetched value until the next successful fetch.

Reset
REQ-032 reset_fetch=1 SHALL immediately force: state IDLE, pc=0, instruction=12'h000, REIR=0, mem_rd_req=0, fetch_busy=0, fetch_err=0, timeout counter=0.
REQ-033 Reset asserted mid-fetch SHALL abort it with no REIR pulse and no pc increment.
REQ-034 First fetch after reset release SHALL read address 8'h00.

Structure
REQ-035 Shared package cpu_pkg SHALL hold INSTR_W, ADDR_W, OPCODE_W=4, ACK_TIMEOUT, and the fetch state encoding.
REQ-036 One sub-module, program_counter (load, increment, async reset), SHALL hold pc.
REQ-037 Target size: 120-400 RTL lines.

Verification
REQ-038 Reset, then fetch_go with memory acking immediately with 12'h4FF -> mem_addr=8'h00, instruction=12'h4FF with REIR for 1 cycle, pc=8'h01.
REQ-039 pc=8'hFF, fetch_go, ack with 12'h0A5 -> REIR pulse, pc=8'h00.
REQ-040 In IDLE, jump_en=1, jump_addr=8'h3C, fetch_go=1 same cycle -> pc=8'h3C, no fetch; next fetch_go -> mem_addr=8'h3C.
REQ-041 fetch_go, ack withheld 16 cycles -> fetch_err single pulse, REIR never high, pc unchanged, fetch_busy low afterward.
REQ-042 halt=1 with fetch_go -> stays IDLE; halt asserted during REQ with ack after 3 cycles -> fetch completes, REIR pulses.
REQ-043 reset_fetch pulsed during REQ -> outputs at reset values immediately, no REIR, pc=8'h00.
